bit_serializer: RTL and testbench



---
 rtl/serial_pkg.sv | 17 +
 rtl/ser_hold_reg.sv | 49 ++++
 rtl/bit_serializer.sv | 134 +++++++++++++
 tb/tb_bit_serializer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// ----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial pattern-detector path. Imported by the
// bit_serializer front end and by the downstream detector benches.
//   ser_state_t : shifter FSM state (IDLE = shifter empty, SHIFT = emitting).
//   SER_DATA_W  : default parallel word width.
// ----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_DATA_W = 8;

endpackage : serial_pkg

// File: rtl/ser_hold_reg.sv
// ----------------------------------------------------------------------------
// ser_hold_reg
// One-entry holding register that parks a word while the shifter is busy.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears the full flag)
//   load       : capture load_data; only asserted while empty
//   load_data  : word to park
//   unload     : hand the parked word to the shifter; only asserted while full
//   full       : a word is parked
//   data       : the parked word (valid while full)
// ----------------------------------------------------------------------------
module ser_hold_reg
    import serial_pkg::*;
#(
    parameter int DATA_W = SER_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              unload,
    output logic              full,
    output logic [DATA_W-1:0] data
);

    logic              full_q;
    logic [DATA_W-1:0] data_q;

    // Occupancy flag is control state and is reset; the word itself is not.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
        end else if (load) begin
            full_q <= 1'b1;
        end else if (unload) begin
            full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= load_data;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule : ser_hold_reg

// File: rtl/bit_serializer.sv
// ----------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial front end: accepts DATA_W-bit words on a valid/ready
// handshake and emits them one bit per clock. A one-word holding register
// lets consecutive words stream with no idle cycles between them.
// Parameters:
//   DATA_W    : word width (>= 2)
//   MSB_FIRST : 1 = bit DATA_W-1 leaves first, 0 = bit 0 leaves first
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_data     : parallel word
//   in_valid    : in_data valid
//   in_ready    : a word can be taken this cycle (holding register empty)
//   bit_out     : serial bit, forced to 0 when bit_valid is low
//   bit_valid   : bit_out carries a real bit
//   frame_start : high with the first bit of each word
//   busy        : shifter or holding register occupied
// ----------------------------------------------------------------------------
module bit_serializer
    import serial_pkg::*;
#(
    parameter int DATA_W    = SER_DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    // Bit currently presented by the shifter.
    function automatic logic head_bit(input logic [DATA_W-1:0] s);
        return MSB_FIRST ? s[DATA_W-1] : s[0];
    endfunction

    // Shifter contents after the head bit has been sent.
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] s);
        if (MSB_FIRST) begin
            return {s[DATA_W-2:0], 1'b0};
        end
        return {1'b0, s[DATA_W-1:1]};
    endfunction

    ser_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;

    logic              hold_full;
    logic [DATA_W-1:0] hold_data;
    logic              hold_load;
    logic              hold_unload;
    logic              accept;
    logic              shifter_frees;

    ser_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load),
        .load_data (in_data),
        .unload    (hold_unload),
        .full      (hold_full),
        .data      (hold_data)
    );

    // Ready depends only on registered occupancy, never on in_valid.
    assign in_ready = ~hold_full;
    assign accept   = in_valid & in_ready;

    // The shifter can take a new word at this edge when it is empty or is
    // presenting its last bit.
    assign shifter_frees = (state_q == IDLE) || (cnt_q == LAST_CNT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_load   = 1'b0;
        hold_unload = 1'b0;

        if (shifter_frees) begin
            // While hold is full in_ready is low, so no word can compete
            // with the unload for the shifter.
            if (hold_full) begin
                shift_d     = hold_data;
                hold_unload = 1'b1;
                cnt_d       = '0;
                state_d     = SHIFT;
            end else if (accept) begin
                shift_d = in_data;
                cnt_d   = '0;
                state_d = SHIFT;
            end else begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        end else begin
            // Mid-word: keep shifting, park any newly accepted word.
            shift_d   = advance(shift_q);
            cnt_d     = cnt_q + CNT_W'(1);
            hold_load = accept;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shifter data needs no reset: it is only observed while in SHIFT.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign bit_valid   = (state_q == SHIFT);
    assign bit_out     = bit_valid & head_bit(shift_q);
    assign frame_start = bit_valid & (cnt_q == '0);
    assign busy        = bit_valid | hold_full;

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// ----------------------------------------------------------------------------
// tb_bit_serializer
// Drives one stimulus stream into an MSB-first and an LSB-first instance.
// Each accepted word pushes its expected bits (with frame flag) into a
// per-instance queue; every cycle the outputs are popped and compared.
// ----------------------------------------------------------------------------
module tb_bit_serializer;
    import serial_pkg::*;

    localparam int W = SER_DATA_W;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;

    logic rdy_m, bo_m, bv_m, fs_m, bz_m;
    logic rdy_l, bo_l, bv_l, fs_l, bz_l;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .bit_out(bo_m), .bit_valid(bv_m),
        .frame_start(fs_m), .busy(bz_m)
    );

    bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .bit_out(bo_l), .bit_valid(bv_l),
        .frame_start(fs_l), .busy(bz_l)
    );

    logic [1:0] q_m[$];   // {frame, bit}
    logic [1:0] q_l[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       last_acc;
    logic [3:0] det_sh;
    int         det_cnt, vcnt, fcnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            q_m.push_back({(i == 0), w[W-1-i]});
            q_l.push_back({(i == 0), w[i]});
        end
    endtask

    task automatic observe();
        logic [1:0] e;
        check_eq("m_busy",  32'(bz_m),  32'(q_m.size() > 0));
        check_eq("m_ready", 32'(rdy_m), 32'(q_m.size() <= W));
        check_eq("l_busy",  32'(bz_l),  32'(q_l.size() > 0));
        check_eq("l_ready", 32'(rdy_l), 32'(q_l.size() <= W));
        if (bv_m) begin
            if (q_m.size() == 0) begin
                check_eq("m_extra_bit", 32'(bv_m), 32'd0);
            end else begin
                e = q_m.pop_front();
                check_eq("m_bit",   32'(bo_m), 32'(e[0]));
                check_eq("m_frame", 32'(fs_m), 32'(e[1]));
            end
            det_sh = {det_sh[2:0], bo_m};
            if (det_sh == 4'b1100) det_cnt++;
            vcnt++;
            if (fs_m) fcnt++;
        end else begin
            check_eq("m_gap_pending", 32'(q_m.size()), 32'd0);
            check_eq("m_bit_idle",    32'(bo_m), 32'd0);
            check_eq("m_frame_idle",  32'(fs_m), 32'd0);
        end
        if (bv_l) begin
            if (q_l.size() == 0) begin
                check_eq("l_extra_bit", 32'(bv_l), 32'd0);
            end else begin
                e = q_l.pop_front();
                check_eq("l_bit",   32'(bo_l), 32'(e[0]));
                check_eq("l_frame", 32'(fs_l), 32'(e[1]));
            end
        end else begin
            check_eq("l_gap_pending", 32'(q_l.size()), 32'd0);
            check_eq("l_bit_idle",    32'(bo_l), 32'd0);
            check_eq("l_frame_idle",  32'(fs_l), 32'd0);
        end
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic tick();
        last_acc = in_valid && rdy_m && !rst;
        if (rst) begin
            q_m.delete();
            q_l.delete();
        end else if (last_acc) begin
            push_word(in_data);
        end
        @(posedge clk);
        @(negedge clk);
        observe();
    endtask

    // Holds in_valid high with w until accepted; returns ticks taken.
    task automatic send_word(input logic [W-1:0] w, output int n);
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 40);
        check_eq("accept_timeout", 32'(last_acc), 32'd1);
    endtask

    task automatic clear_stats();
        det_sh  = 4'b0;
        det_cnt = 0;
        vcnt    = 0;
        fcnt    = 0;
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        clear_stats();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid", 32'(bv_m),  32'd0);
        check_eq("rst_busy",  32'(bz_m),  32'd0);
        check_eq("rst_ready", 32'(rdy_m), 32'd1);
        check_eq("rst_frame", 32'(fs_m),  32'd0);

        // Single word 8'hCC
        clear_stats();
        send_word(8'hCC, n);
        in_valid = 1'b0;
        repeat (10) tick();
        check_eq("t1_detect", 32'(det_cnt), 32'd2);
        check_eq("t1_vcnt",   32'(vcnt),    32'd8);
        check_eq("t1_fcnt",   32'(fcnt),    32'd1);

        // Back-to-back C3, 0C
        clear_stats();
        send_word(8'hC3, n);
        send_word(8'h0C, n);
        check_eq("t2_second_wait", 32'(n), 32'd1);
        in_valid = 1'b0;
        repeat (18) tick();
        check_eq("t2_vcnt", 32'(vcnt), 32'd16);
        check_eq("t2_fcnt", 32'(fcnt), 32'd2);

        // Backpressure with three words
        clear_stats();
        send_word(8'hA5, n);
        send_word(8'h3C, n);
        send_word(8'h96, n);
        check_eq("t3_third_wait", 32'(n), 32'd8);
        in_valid = 1'b0;
        repeat (26) tick();
        check_eq("t3_vcnt", 32'(vcnt), 32'd24);

        // LSB-first order check word
        send_word(8'h03, n);
        in_valid = 1'b0;
        repeat (10) tick();

        // Reset mid-word with a word parked in hold
        send_word(8'hCC, n);
        send_word(8'hFF, n);
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5_valid", 32'(bv_m),  32'd0);
        check_eq("t5_busy",  32'(bz_m),  32'd0);
        check_eq("t5_ready", 32'(rdy_m), 32'd1);
        clear_stats();
        repeat (12) tick();
        check_eq("t5_no_resume", 32'(vcnt), 32'd0);

        // Idle gap between F0 and 0F
        send_word(8'hF0, n);
        in_valid = 1'b0;
        repeat (7) tick();
        repeat (3) tick();
        send_word(8'h0F, n);
        in_valid = 1'b0;
        check_eq("t6_frame", 32'(fs_m), 32'd1);
        check_eq("t6_first_bit", 32'(bo_m), 32'd0);
        repeat (9) tick();

        check_eq("end_q_m", 32'(q_m.size()), 32'd0);
        check_eq("end_q_l", 32'(q_l.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bit_serializer
